p4_adder_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one P4 adder instance among N requesters.
- Each requester issues operands over a valid/ready request channel and receives the sum and carry-out over a valid/ready response channel.
- The block drives the adder's a/b/cin from registers, holds them for a programmable settling time, captures s/cout, and returns the result to the granted requester.
- One operation is in flight at a time.

---
 rtl/p4_adder_arbiter.sv | 164 ++++++++++++++++
 tb/tb_p4_adder_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/p4_adder_arbiter.sv
// Round-robin arbiter and sequencer that shares one external P4 adder
// among NREQ requesters. One operation is in flight at a time:
// IDLE (arbitrate/grant) -> EXEC (hold adder inputs) -> RESP (return result).

package p4_adder_pkg;
   typedef logic [31:0] data_t;
endpackage

module p4_adder_arbiter #(
   parameter int NBIT       = $bits(p4_adder_pkg::data_t),
   parameter int NREQ       = 4,
   parameter int ADD_CYCLES = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [NREQ*NBIT-1:0] req_a,
   input  logic [NREQ*NBIT-1:0] req_b,
   input  logic [NREQ-1:0]      req_cin,
   output logic [NREQ-1:0]      rsp_valid,
   input  logic [NREQ-1:0]      rsp_ready,
   output logic [NBIT-1:0]      rsp_s,
   output logic                 rsp_cout,
   output logic [NBIT-1:0]      add_a,
   output logic [NBIT-1:0]      add_b,
   output logic                 add_cin,
   input  logic [NBIT-1:0]      add_s,
   input  logic                 add_cout
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW = (ADD_CYCLES > 1) ? $clog2(ADD_CYCLES) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
   logic [PW-1:0]     owner_q, owner_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [NBIT-1:0]   add_a_q, add_a_d;
   logic [NBIT-1:0]   add_b_q, add_b_d;
   logic              add_cin_q, add_cin_d;
   logic [NBIT-1:0]   rsp_s_q, rsp_s_d;
   logic              rsp_cout_q, rsp_cout_d;
   logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;

   logic              arb_found;
   logic [PW-1:0]     arb_idx;
   logic [PW-1:0]     arb_cand;

   function automatic logic [NREQ-1:0] onehot(input logic [PW-1:0] idx);
      onehot      = '0;
      onehot[idx] = 1'b1;
   endfunction

   // Round-robin search: first valid requester starting at rr_ptr, wrapping.
   always_comb begin
      arb_found = 1'b0;
      arb_idx   = '0;
      arb_cand  = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         arb_cand = PW'((32'(rr_ptr_q) + k) % NREQ);
         if (!arb_found && req_valid[arb_cand]) begin
            arb_found = 1'b1;
            arb_idx   = arb_cand;
         end
      end
   end

   // Accept is offered only to the current winner, only while idle and out of reset.
   always_comb begin
      req_ready = '0;
      if (!rst && state_q == IDLE && arb_found) begin
         req_ready = onehot(arb_idx);
      end
   end

   // Next-state and datapath register updates for the IDLE/EXEC/RESP sequence.
   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      owner_d     = owner_q;
      cnt_d       = cnt_q;
      add_a_d     = add_a_q;
      add_b_d     = add_b_q;
      add_cin_d   = add_cin_q;
      rsp_s_d     = rsp_s_q;
      rsp_cout_d  = rsp_cout_q;
      rsp_valid_d = rsp_valid_q;
      case (state_q)
         IDLE: begin
            if (arb_found) begin
               add_a_d   = req_a[32'(arb_idx)*NBIT +: NBIT];
               add_b_d   = req_b[32'(arb_idx)*NBIT +: NBIT];
               add_cin_d = req_cin[arb_idx];
               owner_d   = arb_idx;
               rr_ptr_d  = (arb_idx == PW'(NREQ-1)) ? '0 : arb_idx + 1'b1;
               cnt_d     = CW'(ADD_CYCLES-1);
               state_d   = EXEC;
            end
         end
         EXEC: begin
            if (cnt_q == '0) begin
               rsp_s_d     = add_s;
               rsp_cout_d  = add_cout;
               rsp_valid_d = onehot(owner_q);
               state_d     = RESP;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         RESP: begin
            if (rsp_ready[owner_q]) begin
               rsp_valid_d = '0;
               state_d     = IDLE;
            end
         end
         default: begin
            rsp_valid_d = '0;
            state_d     = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset discards any in-flight operation.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         rr_ptr_q    <= '0;
         owner_q     <= '0;
         cnt_q       <= '0;
         add_a_q     <= '0;
         add_b_q     <= '0;
         add_cin_q   <= 1'b0;
         rsp_s_q     <= '0;
         rsp_cout_q  <= 1'b0;
         rsp_valid_q <= '0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         owner_q     <= owner_d;
         cnt_q       <= cnt_d;
         add_a_q     <= add_a_d;
         add_b_q     <= add_b_d;
         add_cin_q   <= add_cin_d;
         rsp_s_q     <= rsp_s_d;
         rsp_cout_q  <= rsp_cout_d;
         rsp_valid_q <= rsp_valid_d;
      end
   end

   assign add_a     = add_a_q;
   assign add_b     = add_b_q;
   assign add_cin   = add_cin_q;
   assign rsp_s     = rsp_s_q;
   assign rsp_cout  = rsp_cout_q;
   assign rsp_valid = rsp_valid_q;

endmodule

// File: tb/tb_p4_adder_arbiter.sv
// Self-checking bench for p4_adder_arbiter: table-driven single operations
// plus directed multi-cycle sequences (reset, fairness, backpressure,
// operand isolation, settling time on a second instance).

module tb_p4_adder_arbiter;

   logic         clk;
   logic         rst;

   // Instance with ADD_CYCLES=1
   logic [3:0]   req_valid, req_ready, req_cin, rsp_valid, rsp_ready;
   logic [127:0] req_a, req_b;
   logic [31:0]  rsp_s, add_a, add_b, add_s;
   logic         rsp_cout, add_cin, add_cout;

   // Instance with ADD_CYCLES=3
   logic [3:0]   r3_valid, r3_ready, r3_cin, p3_valid, p3_ready;
   logic [127:0] r3_a, r3_b;
   logic [31:0]  p3_s, a3_a, a3_b, a3_s;
   logic         p3_cout, a3_cin, a3_cout;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      int          id;
      logic [31:0] a;
      logic [31:0] b;
      logic        cin;
      logic [31:0] s;
      logic        cout;
   } vec_t;

   vec_t vecs[8];

   // Behavioural stand-ins for the shared P4 adders
   assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_cin};
   assign {a3_cout, a3_s}   = {1'b0, a3_a} + {1'b0, a3_b} + {32'd0, a3_cin};

   p4_adder_arbiter #(.NBIT(32), .NREQ(4), .ADD_CYCLES(1)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_s(rsp_s), .rsp_cout(rsp_cout),
      .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
      .add_s(add_s), .add_cout(add_cout)
   );

   p4_adder_arbiter #(.NBIT(32), .NREQ(4), .ADD_CYCLES(3)) dut3 (
      .clk(clk), .rst(rst),
      .req_valid(r3_valid), .req_ready(r3_ready),
      .req_a(r3_a), .req_b(r3_b), .req_cin(r3_cin),
      .rsp_valid(p3_valid), .rsp_ready(p3_ready),
      .rsp_s(p3_s), .rsp_cout(p3_cout),
      .add_a(a3_a), .add_b(a3_b), .add_cin(a3_cin),
      .add_s(a3_s), .add_cout(a3_cout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [3:0] oh(input int i);
      return 4'b0001 << i;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready(input int id, input string name);
      int n = 0;
      while (req_ready[id] !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      check(name, {60'd0, req_ready}, {60'd0, oh(id)});
   endtask

   // One complete operation through the ADD_CYCLES=1 instance.
   task automatic do_op(input vec_t v, input string tag);
      req_a[v.id*32 +: 32] = v.a;
      req_b[v.id*32 +: 32] = v.b;
      req_cin[v.id]        = v.cin;
      req_valid            = oh(v.id);
      #1;
      wait_ready(v.id, {tag, "_ready"});
      tick();
      req_valid            = '0;
      req_a[v.id*32 +: 32] = ~v.a;
      req_b[v.id*32 +: 32] = ~v.b;
      #1;
      check({tag, "_busy_ready"}, {60'd0, req_ready}, 64'd0);
      check({tag, "_add_a"}, {32'd0, add_a}, {32'd0, v.a});
      check({tag, "_early_valid"}, {60'd0, rsp_valid}, 64'd0);
      tick();
      check({tag, "_rsp_valid"}, {60'd0, rsp_valid}, {60'd0, oh(v.id)});
      check({tag, "_rsp_s"}, {32'd0, rsp_s}, {32'd0, v.s});
      check({tag, "_rsp_cout"}, {63'd0, rsp_cout}, {63'd0, v.cout});
      rsp_ready = oh(v.id);
      tick();
      rsp_ready = '0;
      check({tag, "_rsp_done"}, {60'd0, rsp_valid}, 64'd0);
   endtask

   initial begin
      logic [32:0] sum;
      int          e;
      int          n;

      vecs[0] = '{2, 32'd5,          32'd7,          1'b1, 32'd13,         1'b0};
      vecs[1] = '{0, 32'hFFFF_FFFF,  32'd1,          1'b0, 32'd0,          1'b1};
      vecs[2] = '{0, 32'h8000_0000,  32'h8000_0000,  1'b1, 32'd1,          1'b1};
      vecs[3] = '{1, 32'h1234_5678,  32'h1111_1111,  1'b0, 32'h2345_6789,  1'b0};
      vecs[4] = '{3, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b1, 32'hFFFF_FFFF,  1'b1};
      vecs[5] = '{1, 32'd0,          32'd0,          1'b1, 32'd1,          1'b0};
      vecs[6] = '{3, 32'h7FFF_FFFF,  32'd1,          1'b0, 32'h8000_0000,  1'b0};
      vecs[7] = '{2, 32'hDEAD_BEEF,  32'h2152_4111,  1'b0, 32'd0,          1'b1};

      rst = 1'b1;
      req_valid = '0; req_a = '0; req_b = '0; req_cin = '0; rsp_ready = '0;
      r3_valid = '0; r3_a = '0; r3_b = '0; r3_cin = '0; p3_ready = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_req_ready", {60'd0, req_ready}, 64'd0);
      check("reset_rsp_valid", {60'd0, rsp_valid}, 64'd0);
      check("reset_add_a", {32'd0, add_a}, 64'd0);
      rst = 1'b0;

      // Reset asserted mid-EXEC clears outputs before the next edge
      req_a[31:0] = 32'd1; req_b[31:0] = 32'd2; req_cin[0] = 1'b1;
      req_valid = 4'b0001;
      #1;
      wait_ready(0, "pre_reset_ready");
      tick();
      req_valid = 4'b0010;
      #1;
      check("exec_add_a", {32'd0, add_a}, 64'd1);
      #1;
      rst = 1'b1;
      #1;
      check("midrst_add_a", {32'd0, add_a}, 64'd0);
      check("midrst_add_b", {32'd0, add_b}, 64'd0);
      check("midrst_add_cin", {63'd0, add_cin}, 64'd0);
      check("midrst_req_ready", {60'd0, req_ready}, 64'd0);
      check("midrst_rsp_valid", {60'd0, rsp_valid}, 64'd0);
      check("midrst_rsp_s", {32'd0, rsp_s}, 64'd0);
      req_valid = '0;
      req_a = '0; req_b = '0; req_cin = '0;
      tick();
      rst = 1'b0;
      repeat (3) begin
         tick();
         check("no_rsp_after_rst", {60'd0, rsp_valid}, 64'd0);
      end

      // Table-driven single operations (first one: requester 2 granted first)
      for (int i = 0; i < 8; i++) begin
         do_op(vecs[i], $sformatf("vec%0d", i));
      end

      // Round-robin fairness from a fresh pointer
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         req_a[i*32 +: 32] = 32'(i*1000 + 1);
         req_b[i*32 +: 32] = 32'(i + 5);
         req_cin[i]        = 1'(i % 2);
      end
      rsp_ready = 4'hF;
      req_valid = 4'hF;
      #1;
      for (int k = 0; k < 6; k++) begin
         e   = k % 4;
         sum = 33'(e*1000 + 1) + 33'(e + 5) + 33'(e % 2);
         wait_ready(e, $sformatf("rr_grant%0d", k));
         tick();
         check($sformatf("rr_busy%0d", k), {60'd0, req_ready}, 64'd0);
         tick();
         check($sformatf("rr_rsp_valid%0d", k), {60'd0, rsp_valid}, {60'd0, oh(e)});
         check($sformatf("rr_rsp_s%0d", k), {32'd0, rsp_s}, {32'd0, sum[31:0]});
         if (k == 5) req_valid = '0;
         tick();
      end
      rsp_ready = '0;

      // Response backpressure: requester 3 holds off, requester 0 waits
      req_a[127:96] = 32'd40; req_b[127:96] = 32'd2; req_cin[3] = 1'b0;
      req_a[31:0] = 32'd7; req_b[31:0] = 32'd8; req_cin[0] = 1'b0;
      req_valid = 4'b1000;
      #1;
      wait_ready(3, "bp_ready");
      tick();
      req_valid = 4'b0001;
      #1;
      check("bp_exec_ready", {60'd0, req_ready}, 64'd0);
      tick();
      check("bp_rsp_valid", {60'd0, rsp_valid}, 64'h8);
      check("bp_rsp_s", {32'd0, rsp_s}, 64'd42);
      for (int j = 0; j < 5; j++) begin
         tick();
         check($sformatf("bp_hold_valid%0d", j), {60'd0, rsp_valid}, 64'h8);
         check($sformatf("bp_hold_s%0d", j), {32'd0, rsp_s}, 64'd42);
         check($sformatf("bp_hold_ready%0d", j), {60'd0, req_ready}, 64'd0);
      end
      rsp_ready = 4'b1000;
      tick();
      rsp_ready = '0;
      check("bp_released_valid", {60'd0, rsp_valid}, 64'd0);
      check("bp_next_ready", {60'd0, req_ready}, 64'h1);
      check("bp_no_early_grant", {32'd0, add_a}, 64'd40);
      tick();
      req_valid = '0;
      check("bp_next_grant", {32'd0, add_a}, 64'd7);
      tick();
      check("bp2_rsp_valid", {60'd0, rsp_valid}, 64'h1);
      check("bp2_rsp_s", {32'd0, rsp_s}, 64'd15);
      rsp_ready = 4'b1110;
      tick();
      check("bp2_nonowner_ignored", {60'd0, rsp_valid}, 64'h1);
      rsp_ready = 4'b0001;
      tick();
      rsp_ready = '0;
      check("bp2_done", {60'd0, rsp_valid}, 64'd0);

      // Operand isolation and non-owner rsp_ready pulse, requester 1
      req_a[63:32] = 32'd10; req_b[63:32] = 32'd1; req_cin[1] = 1'b0;
      req_valid = 4'b0010;
      #1;
      wait_ready(1, "iso_ready");
      tick();
      req_a[63:32] = 32'd99;
      req_valid = '0;
      tick();
      check("iso_rsp_valid", {60'd0, rsp_valid}, 64'h2);
      check("iso_rsp_s", {32'd0, rsp_s}, 64'd11);
      rsp_ready = 4'b1101;
      tick();
      check("iso_nonowner_valid", {60'd0, rsp_valid}, 64'h2);
      check("iso_nonowner_s", {32'd0, rsp_s}, 64'd11);
      rsp_ready = 4'b0010;
      tick();
      rsp_ready = '0;
      check("iso_done", {60'd0, rsp_valid}, 64'd0);

      // Settling time on the ADD_CYCLES=3 instance
      r3_a[31:0] = 32'd100; r3_b[31:0] = 32'd23; r3_cin[0] = 1'b0;
      r3_valid = 4'b0001;
      #1;
      n = 0;
      while (r3_ready[0] !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      check("s3_ready", {60'd0, r3_ready}, 64'h1);
      tick();
      r3_valid = '0;
      r3_a[31:0] = 32'd555;
      for (int j = 0; j < 3; j++) begin
         #1;
         check($sformatf("s3_add_a%0d", j), {32'd0, a3_a}, 64'd100);
         check($sformatf("s3_add_b%0d", j), {32'd0, a3_b}, 64'd23);
         check($sformatf("s3_wait_valid%0d", j), {60'd0, p3_valid}, 64'd0);
         tick();
      end
      check("s3_rsp_valid", {60'd0, p3_valid}, 64'h1);
      check("s3_rsp_s", {32'd0, p3_s}, 64'd123);
      check("s3_rsp_cout", {63'd0, p3_cout}, 64'd0);
      p3_ready = 4'b0001;
      tick();
      p3_ready = '0;
      check("s3_done", {60'd0, p3_valid}, 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
